// File: rtl/load_store_unit.sv
// Load/store unit: sub-word loads/stores to a 64x32 big-endian word memory.
// Optional LSU_ALIGN_CHECK_EN: reject misaligned half/word accesses with Error.
module load_store_unit (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Req,
    input  logic        Write,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [31:0] LoadData,
    output logic        MemoryRead,
    output logic        MemoryWrite,
    output logic [5:0]  MemAddress,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EXT,
        S_MRG,
        S_WR
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [31:0] load_data_q, load_data_d;

    logic        misaligned;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] extracted;
    logic [31:0] merged;
    logic        unused_addr_hi;

    // Upper address bits alias onto the 256-byte space.
    assign unused_addr_hi = ^Addr[31:8];

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = ((Size == 2'b01) && Addr[0]) ||
                        (Size[1] && (Addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Select the addressed big-endian lane and extend it.
    always_comb begin
        rd_byte = 8'h00;
        unique case (addr_q[1:0])
            2'd0: rd_byte = MemReadData[31:24];
            2'd1: rd_byte = MemReadData[23:16];
            2'd2: rd_byte = MemReadData[15:8];
            2'd3: rd_byte = MemReadData[7:0];
            default: rd_byte = 8'h00;
        endcase
        rd_half = addr_q[1] ? MemReadData[15:0] : MemReadData[31:16];
        if (size_q[1]) begin
            extracted = MemReadData;
        end else if (size_q[0]) begin
            extracted = {{16{rd_half[15] & ~uns_q}}, rd_half};
        end else begin
            extracted = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
        end
    end

    // Replace the addressed lane of the read word with store data.
    always_comb begin
        merged = MemReadData;
        if (size_q[0]) begin
            if (addr_q[1]) merged[15:0] = sdata_q[15:0];
            else           merged[31:16] = sdata_q[15:0];
        end else begin
            unique case (addr_q[1:0])
                2'd0: merged[31:24] = sdata_q[7:0];
                2'd1: merged[23:16] = sdata_q[7:0];
                2'd2: merged[15:8]  = sdata_q[7:0];
                2'd3: merged[7:0]   = sdata_q[7:0];
                default: merged = MemReadData;
            endcase
        end
    end

    // Next-state, capture and completion logic.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        load_data_d = load_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (Req) begin
                    write_d = Write;
                    size_d  = Size;
                    uns_d   = Unsigned;
                    addr_d  = Addr[7:0];
                    sdata_d = StoreData;
                    if (misaligned) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else if (!Write) begin
                        state_d = S_RD;
                    end else if (Size[1]) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = write_q ? S_MRG : S_EXT;
            end
            S_EXT: begin
                load_data_d = extracted;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            S_MRG, S_WR: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory strobes decode from state alone so reset drops them at once.
    always_comb begin
        MemoryRead   = 1'b0;
        MemoryWrite  = 1'b0;
        MemAddress   = 6'd0;
        MemWriteData = 32'd0;
        unique case (state_q)
            S_RD: begin
                MemoryRead = 1'b1;
                MemAddress = addr_q[7:2];
            end
            S_MRG: begin
                MemoryWrite  = 1'b1;
                MemAddress   = addr_q[7:2];
                MemWriteData = merged;
            end
            S_WR: begin
                MemoryWrite  = 1'b1;
                MemAddress   = addr_q[7:2];
                MemWriteData = sdata_q;
            end
            default: ;
        endcase
    end

    // State and captured request registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= 8'h00;
            sdata_q     <= 32'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            load_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            load_data_q <= load_data_d;
        end
    end

    assign Busy     = (state_q != S_IDLE);
    assign Done     = done_q;
    assign Error    = error_q;
    assign LoadData = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: memory model, reference model and per-cycle
// compare process, plus literal expectations for the key scenarios.
module tb_load_store_unit;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req = 1'b0;
    logic        Write = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Unsigned = 1'b0;
    logic [31:0] Addr = 32'd0;
    logic [31:0] StoreData = 32'd0;
    logic        Busy, Done, Error;
    logic [31:0] LoadData;
    logic        MemoryRead, MemoryWrite;
    logic [5:0]  MemAddress;
    logic [31:0] MemWriteData;
    logic [31:0] MemReadData = 32'd0;

    load_store_unit dut (
        .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .Write(Write),
        .Size(Size), .Unsigned(Unsigned), .Addr(Addr),
        .StoreData(StoreData), .Busy(Busy), .Done(Done), .Error(Error),
        .LoadData(LoadData), .MemoryRead(MemoryRead),
        .MemoryWrite(MemoryWrite), .MemAddress(MemAddress),
        .MemWriteData(MemWriteData), .MemReadData(MemReadData)
    );

    always #5 Clock = ~Clock;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];

    always @(posedge Clock) begin
        if (MemoryRead) MemReadData <= mem[MemAddress];
        if (MemoryWrite) mem[MemAddress] <= MemWriteData;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    bit          mon_en = 1'b0;
    bit          op_active = 1'b0;
    int          cyc = 0;
    int          exp_lat;
    bit          exp_rd, exp_wr, exp_err;
    logic [5:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] model_ld = 32'd0;

    always @(negedge Clock) begin
        if (mon_en && Reset_n) begin
            check("rw_excl", {31'd0, MemoryRead & MemoryWrite}, 32'd0);
            if (!MemoryWrite) check("wdata_idle", MemWriteData, 32'd0);
            if (!MemoryRead && !MemoryWrite)
                check("addr_idle", {26'd0, MemAddress}, 32'd0);
            if (op_active) begin
                cyc++;
                check("busy", {31'd0, Busy}, {31'd0, cyc <= exp_lat});
                check("mem_read", {31'd0, MemoryRead},
                      {31'd0, exp_rd && cyc == 1});
                check("mem_write", {31'd0, MemoryWrite},
                      {31'd0, exp_wr && cyc == exp_lat});
                if (MemoryRead || MemoryWrite)
                    check("mem_addr", {26'd0, MemAddress}, {26'd0, exp_addr});
                if (MemoryWrite) check("wdata", MemWriteData, exp_wdata);
                check("done", {31'd0, Done}, {31'd0, cyc == exp_lat + 1});
                if (Done) begin
                    check("load_data", LoadData, model_ld);
                    check("error", {31'd0, Error}, {31'd0, exp_err});
                    op_active = 1'b0;
                end else if (cyc > exp_lat + 2) begin
                    check("timeout", 32'd1, 32'd0);
                    op_active = 1'b0;
                end
            end else begin
                check("idle_busy", {31'd0, Busy}, 32'd0);
                check("idle_done", {31'd0, Done}, 32'd0);
                check("idle_err", {31'd0, Error}, 32'd0);
                check("idle_rd", {31'd0, MemoryRead}, 32'd0);
                check("idle_wr", {31'd0, MemoryWrite}, 32'd0);
            end
        end
    end

    // Reference model: compute expectations for one request, then drive it.
    task automatic op(input bit w, input logic [1:0] sz, input bit u,
                      input logic [31:0] a, input logic [31:0] sd,
                      input bit hold);
        int          idx;
        int          sh;
        bit          mis;
        logic [31:0] word, v, nw;
        int          guard;
        idx  = int'(a[7:2]);
        word = ref_mem[idx];
        mis  = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`endif
        exp_addr  = a[7:2];
        exp_err   = mis;
        exp_wdata = 32'd0;
        nw        = word;
        if (mis) begin
            exp_lat = 0; exp_rd = 0; exp_wr = 0;
        end else if (!w) begin
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
            if (sz[1]) begin
                v = word;
            end else if (sz == 2'b01) begin
                sh = a[1] ? 0 : 16;
                v = (word >> sh) & 32'hFFFF;
                if (!u && v[15]) v = v | 32'hFFFF0000;
            end else begin
                sh = (3 - int'(a[1:0])) * 8;
                v = (word >> sh) & 32'hFF;
                if (!u && v[7]) v = v | 32'hFFFFFF00;
            end
        end else if (sz[1]) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 1;
            nw = sd;
        end else begin
            exp_lat = 2; exp_rd = 1; exp_wr = 1;
            if (sz == 2'b01) begin
                sh = a[1] ? 0 : 16;
                nw = (word & ~(32'hFFFF << sh)) | ((sd & 32'hFFFF) << sh);
            end else begin
                sh = (3 - int'(a[1:0])) * 8;
                nw = (word & ~(32'hFF << sh)) | ((sd & 32'hFF) << sh);
            end
        end
        exp_wdata = nw;
        Write = w; Size = sz; Unsigned = u; Addr = a; StoreData = sd;
        Req = 1'b1;
        @(posedge Clock); #1;
        cyc = 0;
        op_active = 1'b1;
        if (!mis && !w) model_ld = v;
        if (hold) begin
            repeat (exp_lat) @(posedge Clock);
            #1;
        end
        Req = 1'b0;
        guard = 0;
        while (op_active && guard < 10) begin
            @(posedge Clock);
            guard++;
        end
        #1;
        if (op_active) begin
            check("op_hang", 32'd1, 32'd0);
            op_active = 1'b0;
        end
        ref_mem[idx] = nw;
        check("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        mem[0] = 32'h80F00000;  ref_mem[0] = 32'h80F00000;
        mem[8] = 32'h11223344;  ref_mem[8] = 32'h11223344;

        #12;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_err", {31'd0, Error}, 32'd0);
        check("rst_ld", LoadData, 32'd0);
        check("rst_rd", {31'd0, MemoryRead}, 32'd0);
        check("rst_wr", {31'd0, MemoryWrite}, 32'd0);
        check("rst_addr", {26'd0, MemAddress}, 32'd0);
        check("rst_wdata", MemWriteData, 32'd0);
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        mon_en = 1'b1;
        @(posedge Clock); #1;

        op(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
        check("lit_sw_mem", mem[4], 32'hDEADBEEF);
        op(0, 2'b10, 0, 32'h10, 32'h0, 0);
        check("lit_lw", LoadData, 32'hDEADBEEF);

        op(1, 2'b00, 0, 32'h22, 32'h000000AA, 0);
        check("lit_sb_mem", mem[8], 32'h1122AA44);

        op(0, 2'b00, 0, 32'h00, 32'h0, 0);
        check("lit_lb", LoadData, 32'hFFFFFF80);
        op(0, 2'b00, 1, 32'h00, 32'h0, 0);
        check("lit_lbu", LoadData, 32'h00000080);
        op(0, 2'b01, 0, 32'h02, 32'h0, 0);
        check("lit_lh2", LoadData, 32'h00000000);
        op(0, 2'b01, 0, 32'h00, 32'h0, 0);
        check("lit_lh0", LoadData, 32'hFFFF80F0);
        op(0, 2'b01, 1, 32'h00, 32'h0, 0);
        check("lit_lhu0", LoadData, 32'h000080F0);

        op(0, 2'b10, 0, 32'h06, 32'h0, 0);
`ifdef LSU_ALIGN_CHECK_EN
        check("lit_lw_mis", LoadData, 32'h000080F0);
`else
        check("lit_lw_mis", LoadData, 32'h00000000);
`endif

        op(1, 2'b01, 0, 32'h12, 32'h12345678, 0);
        check("lit_sh_mem", mem[4], 32'hDEAD5678);
        op(1, 2'b01, 0, 32'h10, 32'h0000CAFE, 0);
        op(0, 2'b01, 1, 32'h11, 32'h0, 0);

        op(1, 2'b10, 0, 32'h104, 32'hCAFEF00D, 0);
        check("lit_alias_mem", mem[1], 32'hCAFEF00D);
        op(0, 2'b11, 0, 32'h304, 32'h0, 0);
        check("lit_size3_ld", LoadData, 32'hCAFEF00D);
        op(1, 2'b11, 0, 32'h08, 32'h01020304, 0);
        op(1, 2'b00, 0, 32'h0B, 32'h77777799, 0);
        check("lit_sb3_mem", mem[2], 32'h01020399);

        op(0, 2'b00, 0, 32'h23, 32'h0, 1);
        check("lit_hold_lb", LoadData, 32'h00000044);
        op(0, 2'b00, 0, 32'h09, 32'h0, 1);

        mon_en = 1'b0;
        Write = 1'b1; Size = 2'b00; Unsigned = 1'b0;
        Addr = 32'h20; StoreData = 32'h55; Req = 1'b1;
        @(posedge Clock); #1;
        Req = 1'b0;
        @(posedge Clock); #1;
        check("mrg_wr_on", {31'd0, MemoryWrite}, 32'd1);
        Reset_n = 1'b0;
        #1;
        check("rst_wr_drop", {31'd0, MemoryWrite}, 32'd0);
        check("rst_busy_drop", {31'd0, Busy}, 32'd0);
        check("rst_no_done", {31'd0, Done}, 32'd0);
        check("rst_ld_clr", LoadData, 32'd0);
        @(posedge Clock); #1;
        check("rst_mem_keep", mem[8], 32'h1122AA44);
        check("rst_no_done2", {31'd0, Done}, 32'd0);
        Reset_n = 1'b1;
        model_ld = 32'd0;
        @(posedge Clock); #1;
        mon_en = 1'b1;

        op(0, 2'b00, 1, 32'h21, 32'h0, 0);
        check("lit_post_rst", LoadData, 32'h00000022);

        repeat (2) @(posedge Clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
